puf_tx_scheduler: RTL and testbench
===================================

Name: puf_tx_scheduler

Overview:
- Round-robin scheduler that shares the single UART transmitter between N_REQ requesters (ring-oscillator PUF response readout, debug/status words).
- Each requester offers one WORD_BYTES-byte word. The scheduler accepts it, optionally prepends a header byte, and feeds the bytes one at a time into the UART transmitter using its tx_enable/tx_busy handshake.
- Sits between the PUF core/capture logic and the UART transmitter.

Parameters:
N_REQ, 2, number of requesters (1..8)
WORD_BYTES, 4, bytes per request word (1..16)
HEADER_EN, 1, 1 = send header byte {4'hA, 1'b0, id[2:0]} before payload; 0 = payload only
ARM_TIMEOUT, 255, cycles to wait for uart_tx_busy to rise after arming before aborting

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester word available; must stay high with word stable until req_ready
req_word  in  N_REQ*WORD_BYTES*8  requester i word at bits [i*W+W-1 : i*W], where W = WORD_BYTES*8
req_ready  out  N_REQ  one-cycle one-hot pulse; the word has been captured
uart_data  out  8  byte to the UART transmitter
uart_tx_enable  out  1  request to the UART transmitter to start a frame
uart_tx_busy  in  1  UART transmitter busy flag
sched_busy  out  1  high from grant until the last byte completes
active_id  out  3  index of the requester being served; valid while sched_busy
msg_done  out  1  one-cycle pulse after the last byte of a message completes
timeout_err  out  1  one-cycle pulse on ARM timeout

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs 0; RR pointer = N_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: wait for any req_valid AND uart_tx_busy==0 (the transmitter has no reset and may still be finishing a frame). The guard holds in IDLE; once the guard passes, go to GRANT.
  - GRANT (1 cycle): search from ptr+1, wrapping modulo N_REQ, for the first asserted req_valid. Capture its word into a shift buffer. Pulse req_ready[id]. Set active_id, ptr <= id, sched_busy <= 1. Byte counter = 0. Then go to ARM.
  - ARM: drive uart_data = current byte and uart_tx_enable = 1. Hold both stable until uart_tx_busy is sampled 1.
    - On busy = 1: uart_tx_enable <= 0, go to WAIT_DONE.
    - If busy stays low for ARM_TIMEOUT cycles: pulse timeout_err, drop enable, drop the rest of the message, sched_busy <= 0, go to IDLE. No msg_done.
  - WAIT_DONE: wait for uart_tx_busy==0, then go to NEXT. uart_data is held unchanged during this state.
  - NEXT (1 cycle): if the last byte was sent, pulse msg_done, sched_busy <= 0, go to IDLE. Otherwise advance the byte and go to ARM.
- Byte order:
  - Header byte first when HEADER_EN = 1.
  - Then req_word byte 0 (bits [7:0]), byte 1, and so on, ending with byte WORD_BYTES-1.
  - Total bytes per message = WORD_BYTES + HEADER_EN.
- Byte counter width: clog2(WORD_BYTES+2). Wrap is impossible; the counter is cleared in GRANT.
- A requester dropping req_valid before it is granted is legal and is simply not served. Changing req_word after req_ready does not affect the message in flight.
- A request arriving during a message waits. Fairness: a requester granted once is not granted again while another requester is continuously valid.
- Minimum gap between messages: NEXT → IDLE → GRANT is 2 cycles.
- Reset mid-message: the current message is lost and no msg_done is pulsed. The next grant waits for uart_tx_busy==0 via the IDLE guard.

Decomposition:
- Package puf_uart_pkg:
  - State encoding constants IDLE, GRANT, ARM, WAIT_DONE, NEXT.
  - HEADER_TAG = 4'hA.
  - Function computing message length from WORD_BYTES and HEADER_EN.
- Sub-module rr_arbiter (N_REQ parameter): inputs req vector, pointer, enable; outputs one-hot grant and binary id. It is purely combinational plus the pointer register, kept separate for reuse by other shared resources.
- The byte shift buffer and FSM stay in puf_tx_scheduler.

Test Plan:
- Single request, N_REQ=2, WORD_BYTES=4, HEADER_EN=1: req_valid=2'b01, word0=32'hDEADBEEF → req_ready=2'b01 one pulse; the UART model sees bytes A0, EF, BE, AD, DE in order; msg_done pulses once; sched_busy falls in the same cycle msg_done pulses.
- Contention with round robin: both req_valid held high, word0=32'h11111111, word1=32'h22222222, requesters re-raise after ready → grant order 0, 1, 0, 1; headers A0, A1, A0, A1.
- Handshake timing: the UART model delays busy by 5 cycles and holds busy for 100 cycles per byte → uart_tx_enable stays high exactly until busy is sampled; uart_data is stable throughout ARM and WAIT_DONE; no byte is duplicated or skipped.
- Timeout: the model never asserts busy, ARM_TIMEOUT=255 → timeout_err pulses once, 255 cycles after ARM entry; no msg_done; a subsequent valid request is served normally.
- Reset mid-message: assert rst during byte 2 while the model keeps busy=1 for 40 more cycles → all outputs 0 immediately; after release, no grant until busy=0; then a full message from requester 0 is sent.
- HEADER_EN=0, WORD_BYTES=1, word=8'h5A → exactly one byte 5A is sent, followed by msg_done.

Source files
------------

// File: rtl/puf_uart_pkg.sv
// Shared types and constants for the PUF readout UART scheduler.
// State encoding, header tag and message length helper.
package puf_uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        ARM       = 3'd2,
        WAIT_DONE = 3'd3,
        NEXT      = 3'd4
    } sched_state_t;

    localparam logic [3:0] HEADER_TAG = 4'hA;

    function automatic int msg_len(input int word_bytes, input int header_en);
        return word_bytes + ((header_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/puf_tx_scheduler_if.sv
// Requester and UART-side signals of the transmit scheduler.
// master = scheduler view, slave = requesters plus UART transmitter view.
interface puf_tx_scheduler_if #(
    parameter int N_REQ      = 2,
    parameter int WORD_BYTES = 4
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ*WORD_BYTES*8-1:0] req_word;
    logic [N_REQ-1:0]              req_ready;
    logic [7:0]                    uart_data;
    logic                          uart_tx_enable;
    logic                          uart_tx_busy;
    logic                          sched_busy;
    logic [2:0]                    active_id;
    logic                          msg_done;
    logic                          timeout_err;

    modport master (
        input  req_valid, req_word, uart_tx_busy,
        output req_ready, uart_data, uart_tx_enable, sched_busy,
               active_id, msg_done, timeout_err
    );

    modport slave (
        output req_valid, req_word, uart_tx_busy,
        input  req_ready, uart_data, uart_tx_enable, sched_busy,
               active_id, msg_done, timeout_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search from ptr+1, pointer register moves to the winner.
// Grant is valid in the same cycle; the pointer updates only when en is high and someone won.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       id
);

    logic [7:0]       req_pad;
    logic [2:0]       ptr;
    logic [2:0]       idx;
    logic             found;
    logic [N_REQ-1:0] one_hot_base;

    assign req_pad      = 8'(req);
    assign one_hot_base = N_REQ'(1);

    always_comb begin
        id    = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % N_REQ);
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
    end

    assign gnt = found ? (one_hot_base << id) : '0;

    // Reset pointer to the last requester so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 3'(N_REQ - 1);
        end else if (en && found) begin
            ptr <= id;
        end
    end

endmodule

// File: rtl/puf_tx_scheduler.sv
// Shares one UART transmitter among N_REQ word requesters, round robin, optional header byte.
// Grant-to-first-enable is 1 cycle; each byte waits on the tx_enable/tx_busy handshake.
module puf_tx_scheduler
    import puf_uart_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WORD_BYTES  = 4,
    parameter int HEADER_EN   = 1,
    parameter int ARM_TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    puf_tx_scheduler_if.master bus
);

    localparam int W       = WORD_BYTES * 8;
    localparam int MSG_LEN = msg_len(WORD_BYTES, HEADER_EN);
    localparam int BUF_W   = MSG_LEN * 8;
    localparam int CW      = $clog2(WORD_BYTES + 2);
    localparam int TW      = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    sched_state_t     state;
    logic [N_REQ-1:0] arb_gnt;
    logic [2:0]       arb_id;
    logic             arb_any;
    logic             arb_en;
    logic [W-1:0]     sel_word;
    logic [BUF_W-1:0] full_msg;
    logic [BUF_W-1:0] shift_buf;
    logic [CW-1:0]    byte_cnt;
    logic [TW-1:0]    arm_timer;

    logic [N_REQ-1:0] req_ready_q;
    logic [7:0]       uart_data_q;
    logic             tx_en_q;
    logic             sched_busy_q;
    logic [2:0]       active_id_q;
    logic             msg_done_q;
    logic             timeout_err_q;

    assign arb_en = (state == GRANT);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .en  (arb_en),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    assign arb_any = |arb_gnt;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_word = bus.req_word[i*W +: W];
            end
        end
    end

    // Byte 0 of full_msg is the first byte on the wire.
    generate
        if (HEADER_EN != 0) begin : g_hdr
            assign full_msg = {sel_word, HEADER_TAG, 1'b0, arb_id};
        end else begin : g_nohdr
            assign full_msg = sel_word;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shift_buf     <= '0;
            byte_cnt      <= '0;
            arm_timer     <= '0;
            req_ready_q   <= '0;
            uart_data_q   <= '0;
            tx_en_q       <= 1'b0;
            sched_busy_q  <= 1'b0;
            active_id_q   <= '0;
            msg_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            req_ready_q   <= '0;
            msg_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state)
                // The transmitter has no reset, so never start while it is still busy.
                IDLE: begin
                    if (|bus.req_valid && !bus.uart_tx_busy) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (arb_any) begin
                        req_ready_q  <= arb_gnt;
                        active_id_q  <= arb_id;
                        sched_busy_q <= 1'b1;
                        byte_cnt     <= '0;
                        arm_timer    <= '0;
                        uart_data_q  <= full_msg[7:0];
                        shift_buf    <= full_msg >> 8;
                        tx_en_q      <= 1'b1;
                        state        <= ARM;
                    end else begin
                        state <= IDLE;
                    end
                end
                ARM: begin
                    if (bus.uart_tx_busy) begin
                        tx_en_q <= 1'b0;
                        state   <= WAIT_DONE;
                    end else if (arm_timer == TW'(ARM_TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        tx_en_q       <= 1'b0;
                        sched_busy_q  <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        arm_timer <= arm_timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.uart_tx_busy) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (byte_cnt == CW'(MSG_LEN - 1)) begin
                        msg_done_q   <= 1'b1;
                        sched_busy_q <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        byte_cnt    <= byte_cnt + CW'(1);
                        uart_data_q <= shift_buf[7:0];
                        shift_buf   <= shift_buf >> 8;
                        arm_timer   <= '0;
                        tx_en_q     <= 1'b1;
                        state       <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.uart_data      = uart_data_q;
    assign bus.uart_tx_enable = tx_en_q;
    assign bus.sched_busy     = sched_busy_q;
    assign bus.active_id      = active_id_q;
    assign bus.msg_done       = msg_done_q;
    assign bus.timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_puf_tx_scheduler.sv
// Directed bench for puf_tx_scheduler: vector table for single requests plus
// contention, handshake timing, ARM timeout, mid-message reset and a header-less 1-byte build.
module tb_puf_tx_scheduler;

    logic clk;
    logic rst = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    puf_tx_scheduler_if #(.N_REQ(2), .WORD_BYTES(4)) ifa ();
    puf_tx_scheduler_if #(.N_REQ(1), .WORD_BYTES(1)) ifb ();

    puf_tx_scheduler #(.N_REQ(2), .WORD_BYTES(4), .HEADER_EN(1), .ARM_TIMEOUT(255)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    puf_tx_scheduler #(.N_REQ(1), .WORD_BYTES(1), .HEADER_EN(0), .ARM_TIMEOUT(255)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] word;
        logic [1:0]  exp_ready;
        logic [2:0]  exp_id;
        logic [39:0] exp_seq;   // first byte on the wire in [39:32]
        int          delay;
        int          len;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_a = 0;
    int tmo_a  = 0;
    int done_b = 0;
    int hs_err = 0;

    int   busy_delay = 1;
    int   busy_len   = 3;
    bit   uart_dead  = 1'b0;
    bit   hs_chk     = 1'b1;
    logic force_busy = 1'b0;
    logic busy_a     = 1'b0;
    logic busy_b     = 1'b0;

    logic [7:0] bytes_a[$];
    logic [7:0] bytes_b[$];

    assign ifa.uart_tx_busy = busy_a | force_busy;
    assign ifb.uart_tx_busy = busy_b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.msg_done === 1'b1)    done_a <= done_a + 1;
        if (ifa.timeout_err === 1'b1) tmo_a  <= tmo_a + 1;
        if (ifb.msg_done === 1'b1)    done_b <= done_b + 1;
    end

    // UART transmitter model for dut_a: busy rises busy_delay cycles after enable, held busy_len cycles.
    initial begin : uart_model_a
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (ifa.uart_tx_enable === 1'b1 && !busy_a && !uart_dead) begin
                d = ifa.uart_data;
                for (int k = 1; k < busy_delay; k++) begin
                    @(negedge clk);
                    if (hs_chk && (ifa.uart_tx_enable !== 1'b1 || ifa.uart_data !== d)) hs_err++;
                end
                busy_a = 1'b1;
                bytes_a.push_back(d);
                for (int k = 0; k < busy_len; k++) begin
                    @(negedge clk);
                    if (hs_chk && (ifa.uart_tx_enable !== 1'b0 || ifa.uart_data !== d)) hs_err++;
                end
                busy_a = 1'b0;
            end
        end
    end

    initial begin : uart_model_b
        forever begin
            @(negedge clk);
            if (ifb.uart_tx_enable === 1'b1 && !busy_b) begin
                bytes_b.push_back(ifb.uart_data);
                busy_b = 1'b1;
                repeat (3) @(negedge clk);
                busy_b = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] qa(input int i);
        return (i < bytes_a.size()) ? bytes_a[i] : 8'hxx;
    endfunction

    task automatic wait_ready_a(output logic [1:0] rdy, output logic [2:0] id, output logic busy);
        rdy  = '0;
        id   = '0;
        busy = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ifa.req_ready !== 2'b00) begin
                rdy  = ifa.req_ready;
                id   = ifa.active_id;
                busy = ifa.sched_busy;
                return;
            end
        end
    endtask

    task automatic wait_done_a(output logic seen, output logic busy_at);
        seen    = 1'b0;
        busy_at = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (ifa.msg_done === 1'b1) begin
                seen    = 1'b1;
                busy_at = ifa.sched_busy;
                return;
            end
        end
    endtask

    task automatic serve_a(input string tag, input logic [1:0] valid, input logic [31:0] word,
                           input logic [1:0] exp_rdy, input logic [2:0] exp_id, input logic [39:0] exp_seq);
        logic [1:0] rdy;
        logic [2:0] id;
        logic       busy_rdy;
        logic       seen;
        logic       busy_done;
        int         d0;
        d0 = done_a;
        bytes_a.delete();
        ifa.req_word  = valid[0] ? {32'h55555555, word} : {word, 32'h55555555};
        ifa.req_valid = valid;
        wait_ready_a(rdy, id, busy_rdy);
        ifa.req_valid = 2'b00;
        ifa.req_word  = ~ifa.req_word;
        chk({tag, "_ready"}, 64'(rdy), 64'(exp_rdy));
        chk({tag, "_active_id"}, 64'(id), 64'(exp_id));
        chk({tag, "_busy_at_grant"}, 64'(busy_rdy), 64'd1);
        wait_done_a(seen, busy_done);
        chk({tag, "_msg_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy_done), 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_done_count"}, 64'(done_a - d0), 64'd1);
        chk({tag, "_byte_count"}, 64'(bytes_a.size()), 64'd5);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("%s_byte%0d", tag, b), 64'(qa(b)), 64'(exp_seq[39-8*b -: 8]));
        end
    endtask

    logic [1:0]  rdy;
    logic [2:0]  id;
    logic        busy_rdy;
    logic        seen;
    logic        en_at;
    logic        sb_at;
    logic [1:0]  exp_order[4];
    int          d0;
    int          d_pre;
    int          t0;
    int          t1;
    int          tmo0;
    int          viol;

    initial begin
        vecs[0] = '{2'b01, 32'hDEADBEEF, 2'b01, 3'd0, 40'hA0_EF_BE_AD_DE, 1, 3};
        vecs[1] = '{2'b10, 32'h12345678, 2'b10, 3'd1, 40'hA1_78_56_34_12, 2, 4};
        vecs[2] = '{2'b01, 32'hA5C30F81, 2'b01, 3'd0, 40'hA0_81_0F_C3_A5, 5, 100};
        vecs[3] = '{2'b01, 32'h00000000, 2'b01, 3'd0, 40'hA0_00_00_00_00, 1, 1};
        vecs[4] = '{2'b10, 32'hFFFFFFFF, 2'b10, 3'd1, 40'hA1_FF_FF_FF_FF, 3, 2};
        exp_order[0] = 2'b01;
        exp_order[1] = 2'b10;
        exp_order[2] = 2'b01;
        exp_order[3] = 2'b10;

        ifa.req_valid = '0;
        ifa.req_word  = '0;
        ifb.req_valid = '0;
        ifb.req_word  = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 64'(ifa.req_ready), 64'd0);
        chk("rst_tx_enable", 64'(ifa.uart_tx_enable), 64'd0);
        chk("rst_uart_data", 64'(ifa.uart_data), 64'd0);
        chk("rst_sched_busy", 64'(ifa.sched_busy), 64'd0);
        chk("rst_active_id", 64'(ifa.active_id), 64'd0);
        chk("rst_msg_done", 64'(ifa.msg_done), 64'd0);
        chk("rst_timeout_err", 64'(ifa.timeout_err), 64'd0);
        chk("rst_b_tx_enable", 64'(ifb.uart_tx_enable), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single requests, alternating requesters and UART timings.
        for (int v = 0; v < 5; v++) begin
            busy_delay = vecs[v].delay;
            busy_len   = vecs[v].len;
            @(negedge clk);
            serve_a($sformatf("vec%0d", v), vecs[v].valid, vecs[v].word,
                    vecs[v].exp_ready, vecs[v].exp_id, vecs[v].exp_seq);
        end

        // Contention: both valid, each re-raises right after its ready pulse.
        busy_delay = 1;
        busy_len   = 2;
        bytes_a.delete();
        d0 = done_a;
        @(negedge clk);
        ifa.req_word  = {32'h22222222, 32'h11111111};
        ifa.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ready_a(rdy, id, busy_rdy);
            chk($sformatf("rr_grant%0d", g), 64'(rdy), 64'(exp_order[g]));
            chk($sformatf("rr_id%0d", g), 64'(id), 64'(exp_order[g] == 2'b10 ? 1 : 0));
            ifa.req_valid = ifa.req_valid & ~rdy;
            @(negedge clk);
            ifa.req_valid = (g < 3) ? 2'b11 : 2'b00;
        end
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (done_a - d0 >= 4) break;
        end
        repeat (2) @(negedge clk);
        chk("rr_done_count", 64'(done_a - d0), 64'd4);
        chk("rr_byte_count", 64'(bytes_a.size()), 64'd20);
        chk("rr_hdr0", 64'(qa(0)), 64'hA0);
        chk("rr_hdr1", 64'(qa(5)), 64'hA1);
        chk("rr_hdr2", 64'(qa(10)), 64'hA0);
        chk("rr_hdr3", 64'(qa(15)), 64'hA1);
        chk("rr_payload0", 64'(qa(1)), 64'h11);
        chk("rr_payload1", 64'(qa(9)), 64'h22);

        // ARM timeout: transmitter never answers.
        uart_dead = 1'b1;
        d0   = done_a;
        tmo0 = tmo_a;
        @(negedge clk);
        ifa.req_word  = {32'h0, 32'h13572468};
        ifa.req_valid = 2'b01;
        wait_ready_a(rdy, id, busy_rdy);
        t0 = cyc;
        ifa.req_valid = 2'b00;
        chk("tmo_ready", 64'(rdy), 64'h1);
        chk("tmo_arm_enable", 64'(ifa.uart_tx_enable), 64'd1);
        seen  = 1'b0;
        t1    = t0;
        en_at = 1'b1;
        sb_at = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ifa.timeout_err === 1'b1) begin
                seen  = 1'b1;
                t1    = cyc;
                en_at = ifa.uart_tx_enable;
                sb_at = ifa.sched_busy;
                break;
            end
        end
        chk("tmo_seen", 64'(seen), 64'd1);
        chk("tmo_latency", 64'(t1 - t0), 64'd255);
        chk("tmo_enable_dropped", 64'(en_at), 64'd0);
        chk("tmo_sched_busy", 64'(sb_at), 64'd0);
        @(negedge clk);
        chk("tmo_pulse_width", 64'(ifa.timeout_err), 64'd0);
        repeat (2) @(negedge clk);
        chk("tmo_count", 64'(tmo_a - tmo0), 64'd1);
        chk("tmo_no_msg_done", 64'(done_a - d0), 64'd0);
        uart_dead = 1'b0;
        @(negedge clk);
        serve_a("post_tmo", 2'b01, 32'h0BADF00D, 2'b01, 3'd0, 40'hA0_0D_F0_AD_0B);

        // Reset during byte 2 while the transmitter stays busy afterwards.
        busy_delay = 1;
        busy_len   = 3;
        bytes_a.delete();
        d_pre = done_a;
        @(negedge clk);
        ifa.req_word  = {32'h0, 32'hCAFEF00D};
        ifa.req_valid = 2'b01;
        wait_ready_a(rdy, id, busy_rdy);
        ifa.req_valid = 2'b00;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bytes_a.size() >= 3) break;
        end
        chk("rstmid_reached_byte2", 64'(bytes_a.size()), 64'd3);
        hs_chk     = 1'b0;
        force_busy = 1'b1;
        rst        = 1'b1;
        #1;
        chk("rstmid_tx_enable", 64'(ifa.uart_tx_enable), 64'd0);
        chk("rstmid_uart_data", 64'(ifa.uart_data), 64'd0);
        chk("rstmid_sched_busy", 64'(ifa.sched_busy), 64'd0);
        chk("rstmid_req_ready", 64'(ifa.req_ready), 64'd0);
        chk("rstmid_msg_done", 64'(ifa.msg_done), 64'd0);
        ifa.req_word  = {32'h0, 32'h01020304};
        ifa.req_valid = 2'b01;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        viol = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ifa.req_ready !== 2'b00 || ifa.sched_busy !== 1'b0 || ifa.uart_tx_enable !== 1'b0) viol++;
        end
        chk("rstmid_guard_holds", 64'(viol), 64'd0);
        force_busy = 1'b0;
        hs_chk     = 1'b1;
        serve_a("rstmid_after", 2'b01, 32'h01020304, 2'b01, 3'd0, 40'hA0_04_03_02_01);
        chk("rstmid_total_done", 64'(done_a - d_pre), 64'd1);

        // Header-less single-byte build.
        @(negedge clk);
        ifb.req_word  = 8'h5A;
        ifb.req_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ifb.req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        ifb.req_valid = 1'b0;
        chk("b_ready", 64'(seen), 64'd1);
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ifb.msg_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b_msg_done_seen", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        chk("b_byte_count", 64'(bytes_b.size()), 64'd1);
        chk("b_byte0", 64'((bytes_b.size() > 0) ? bytes_b[0] : 8'hxx), 64'h5A);
        chk("b_done_count", 64'(done_b), 64'd1);

        chk("handshake_errors", 64'(hs_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
